// File: rtl/data_memory_resp.sv
// Word-organised data-memory responder for the MEM stage: fixed-latency req/ack
// access with pipeline stall, misalignment and range checking.
module data_memory_resp #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic            r_err;
  logic [IW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_ack;
  logic            r_err_o;
  logic [31:0]     r_mem [DEPTH];

  logic            w_in_err;
  logic [IW-1:0]   w_in_idx;
  logic            w_accept;
  logic            w_fast;
  logic            w_slow;
  logic            w_do_access;
  logic            w_acc_we;
  logic            w_acc_err;
  logic [IW-1:0]   w_acc_idx;
  logic [31:0]     w_acc_wdata;

  assign w_in_err = (addr_i[1:0] != 2'b00) || (addr_i[31:2] >= 30'(DEPTH));
  assign w_in_idx = addr_i[IW+1:2];
  assign w_accept = (r_state == S_IDLE) && req_i;
  assign w_fast   = w_accept && (LATENCY == 1);
  assign w_slow   = (r_state == S_BUSY) && (r_cnt == '0);

  // With LATENCY=1 the access happens on the acceptance edge itself, so the
  // live inputs stand in for the not-yet-latched request.
  assign w_acc_we    = w_fast ? we_i     : r_we;
  assign w_acc_err   = w_fast ? w_in_err : r_err;
  assign w_acc_idx   = w_fast ? w_in_idx : r_idx;
  assign w_acc_wdata = w_fast ? wdata_i  : r_wdata;
  assign w_do_access = rst_n_i && (w_fast || w_slow);

  // Array is not reset; the rst_n_i term above drops a store caught by reset.
  always_ff @(posedge clk_i) begin
    if (w_do_access && w_acc_we && !w_acc_err) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_err   <= w_in_err;
            r_idx   <= w_in_idx;
            r_wdata <= wdata_i;
            if (LATENCY == 1) begin
              r_state <= S_DONE;
              r_ack   <= 1'b1;
              r_err_o <= w_in_err;
            end else begin
              r_cnt   <= 4'(LATENCY - 2);
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_ack   <= 1'b1;
            r_err_o <= r_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err_o <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err_o <= 1'b0;
        end
      endcase

      // Only a completing load touches rdata; erroneous loads return zero.
      if (w_do_access && !w_acc_we) begin
        r_rdata <= w_acc_err ? '0 : r_mem[w_acc_idx];
      end
    end
  end

  assign rdata_o = r_rdata;
  assign ack_o   = r_ack;
  assign err_o   = r_err_o;
  assign stall_o = req_i & ~r_ack;

endmodule

// File: tb/tb_data_memory_resp.sv
// Self-checking bench for data_memory_resp: LATENCY=4 and LATENCY=1 instances
// checked against a word-array reference model.
module tb_data_memory_resp;

  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req4, we4, ack4, err4, stall4;
  logic [31:0] addr4, wdata4, rdata4;
  logic        req1, we1, ack1, err1, stall1;
  logic [31:0] addr1, wdata1, rdata1;

  data_memory_resp #(.LATENCY(4), .DEPTH(DEPTH)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req4), .we_i(we4), .addr_i(addr4),
    .wdata_i(wdata4), .rdata_o(rdata4), .ack_o(ack4), .err_o(err4), .stall_o(stall4)
  );

  data_memory_resp #(.LATENCY(1), .DEPTH(DEPTH)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .rdata_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: word array keyed by word index, plus last load result.
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd;

  function automatic bit ref_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= DEPTH * 4);
  endfunction

  function automatic logic [31:0] ref_apply(input bit we, input logic [31:0] addr,
                                            input logic [31:0] wdata);
    bit e;
    e = ref_err(addr);
    if (we) begin
      if (!e) ref_mem[int'(addr / 4)] = wdata;
    end else begin
      ref_rd = e ? 32'h0 : ref_mem[int'(addr / 4)];
    end
    return ref_rd;
  endfunction

  // Drives one request on dut4 and reports what came back; lat=-1 on timeout.
  task automatic access4(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit scramble, output int lat, output logic [31:0] rd,
                         output logic er, output int stall_bad);
    lat = -1; rd = '0; er = 1'b0; stall_bad = 0;
    @(negedge clk);
    req4 = 1'b1; we4 = we; addr4 = addr; wdata4 = wdata;
    #1 if (stall4 !== 1'b1) stall_bad++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (scramble && c == 1) begin
        addr4 = $urandom; wdata4 = $urandom; we4 = ~we;
      end
      if (ack4 === 1'b1) begin
        lat = c; rd = rdata4; er = err4;
        if (stall4 !== 1'b0) stall_bad++;
        break;
      end else if (stall4 !== 1'b1) begin
        stall_bad++;
      end
    end
    @(negedge clk);
    req4 = 1'b0;
  endtask

  task automatic test_reset;
    int lat, sb, acks;
    logic [31:0] rd, exp;
    logic er;
    rst_n = 1'b0;
    req4 = 0; we4 = 0; addr4 = '0; wdata4 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack4 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack4); end
    n_cmp++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err4); end
    n_cmp++; if (rdata4 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata4); end
    n_cmp++; if (stall4 !== 1'b0) begin n_fail++; $display("FAIL reset_stall_lo: got %b want 0", stall4); end
    req4 = 1'b1;
    #1;
    n_cmp++; if (stall4 !== 1'b1) begin n_fail++; $display("FAIL reset_stall_hi: got %b want 1", stall4); end
    @(negedge clk);
    req4 = 1'b0;
    rst_n = 1'b1;
    ref_rd = '0;
    @(negedge clk);
    n_cmp++; if (ack4 !== 1'b0 || ack1 !== 1'b0) begin n_fail++; $display("FAIL post_reset_ack: got %b/%b want 0/0", ack4, ack1); end

    exp = ref_apply(1'b1, 32'h10, 32'hA5A5_0010);
    access4(1'b1, 32'h10, 32'hA5A5_0010, 1'b0, lat, rd, er, sb);
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL pre_store_lat: got %0d want 4", lat); end

    // store of a new value to 0x10, abandoned by reset two cycles in
    @(negedge clk);
    req4 = 1'b1; we4 = 1'b1; addr4 = 32'h10; wdata4 = 32'h1111_2222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; req4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_rd = '0;
    n_cmp++; if (rdata4 !== 32'h0) begin n_fail++; $display("FAIL midreset_rdata: got %h want 0", rdata4); end
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack4 === 1'b1) acks++;
    end
    n_cmp++; if (acks != 0) begin n_fail++; $display("FAIL midreset_ack: got %0d acks want 0", acks); end
    exp = ref_apply(1'b0, 32'h10, '0);
    access4(1'b0, 32'h10, '0, 1'b0, lat, rd, er, sb);
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL midreset_store_dropped: got %h want %h", rd, exp); end
  endtask

  task automatic test_store_load;
    int lat, sb;
    logic [31:0] rd, exp;
    logic er;
    exp = ref_apply(1'b1, 32'h40, 32'hDEAD_BEEF);
    access4(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, lat, rd, er, sb);
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL store_lat: got %0d want 4", lat); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b want 0", er); end
    n_cmp++; if (sb != 0) begin n_fail++; $display("FAIL store_stall: got %0d bad cycles want 0", sb); end
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL store_rdata_hold: got %h want %h", rd, exp); end
    exp = ref_apply(1'b0, 32'h40, '0);
    access4(1'b0, 32'h40, '0, 1'b0, lat, rd, er, sb);
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL load_lat: got %0d want 4", lat); end
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL load_data: got %h want %h", rd, exp); end
    n_cmp++; if (sb != 0) begin n_fail++; $display("FAIL load_stall: got %0d bad cycles want 0", sb); end
  endtask

  task automatic test_misaligned;
    int lat, sb;
    logic [31:0] rd, exp;
    logic er;
    exp = ref_apply(1'b1, 32'h42, 32'h1234_5678);
    access4(1'b1, 32'h42, 32'h1234_5678, 1'b0, lat, rd, er, sb);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_store_err: got %b want 1", er); end
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL mis_store_rdata: got %h want %h", rd, exp); end
    exp = ref_apply(1'b0, 32'h40, '0);
    access4(1'b0, 32'h40, '0, 1'b0, lat, rd, er, sb);
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL mis_no_write: got %h want %h", rd, exp); end
    exp = ref_apply(1'b0, 32'h41, '0);
    access4(1'b0, 32'h41, '0, 1'b0, lat, rd, er, sb);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_load_err: got %b want 1", er); end
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL mis_load_rdata: got %h want %h", rd, exp); end
  endtask

  task automatic test_out_of_range;
    int lat, sb;
    logic [31:0] rd, exp;
    logic er;
    exp = ref_apply(1'b1, 32'h3FC, 32'hCAFE_F00D);
    access4(1'b1, 32'h3FC, 32'hCAFE_F00D, 1'b0, lat, rd, er, sb);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL oor_top_store_err: got %b want 0", er); end
    exp = ref_apply(1'b1, 32'h400, 32'h0BAD_0BAD);
    access4(1'b1, 32'h400, 32'h0BAD_0BAD, 1'b0, lat, rd, er, sb);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_store_err: got %b want 1", er); end
    exp = ref_apply(1'b0, 32'h400, '0);
    access4(1'b0, 32'h400, '0, 1'b0, lat, rd, er, sb);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_load_err: got %b want 1", er); end
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL oor_load_rdata: got %h want %h", rd, exp); end
    exp = ref_apply(1'b0, 32'h3FC, '0);
    access4(1'b0, 32'h3FC, '0, 1'b0, lat, rd, er, sb);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL top_load_err: got %b want 0", er); end
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL top_load_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_input_stability;
    int lat, sb;
    logic [31:0] rd, exp;
    logic er;
    exp = ref_apply(1'b1, 32'h80, 32'h5A5A_C3C3);
    access4(1'b1, 32'h80, 32'h5A5A_C3C3, 1'b1, lat, rd, er, sb);
    n_cmp++; if (lat != 4 || er !== 1'b0) begin n_fail++; $display("FAIL stab_store: got lat %0d err %b want 4/0", lat, er); end
    exp = ref_apply(1'b0, 32'h80, '0);
    access4(1'b0, 32'h80, '0, 1'b1, lat, rd, er, sb);
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL stab_load: got %h want %h", rd, exp); end
  endtask

  task automatic test_random;
    int lat, sb;
    logic [31:0] rd, exp, addr, wdata;
    logic er;
    bit we, e;
    int kind;
    for (int i = 0; i < 16; i++) begin
      wdata = $urandom;
      exp = ref_apply(1'b1, 32'(i * 4), wdata);
      access4(1'b1, 32'(i * 4), wdata, 1'b0, lat, rd, er, sb);
      n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL rnd_init_lat[%0d]: got %0d want 4", i, lat); end
    end
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (kind == 1) addr = 32'($urandom_range(DEPTH, 4000) * 4);
      else if (kind == 2) addr = 32'h3FC;
      else                addr = 32'($urandom_range(0, 15) * 4);
      we = 1'($urandom_range(0, 1));
      wdata = $urandom;
      e = ref_err(addr);
      exp = ref_apply(we, addr, wdata);
      access4(we, addr, wdata, 1'($urandom_range(0, 1)), lat, rd, er, sb);
      n_cmp++;
      if (lat != 4 || er !== e || rd !== exp || sb != 0) begin
        n_fail++;
        $display("FAIL rnd[%0d] we=%0b addr=%h: got lat %0d err %b rd %h stall_bad %0d want 4 %b %h 0",
                 i, we, addr, lat, er, rd, sb, e, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    logic [31:0] oaddr [6];
    bit          owe [6];
    int k, last, sb, extra;
    for (int i = 0; i < 3; i++) begin
      vals[i] = $urandom;
      oaddr[i] = 32'(i * 4);     owe[i] = 1'b1;
      oaddr[i + 3] = 32'(i * 4); owe[i + 3] = 1'b0;
    end
    k = 0; last = 0; sb = 0;
    @(negedge clk);
    req1 = 1'b1; we1 = owe[0]; addr1 = oaddr[0]; wdata1 = vals[0];
    for (int c = 1; c <= 40 && k < 6; c++) begin
      @(posedge clk); #1;
      if (ack1 === 1'b1) begin
        n_cmp++;
        if (c - last != (k == 0 ? 1 : 2)) begin
          n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, c - last, (k == 0 ? 1 : 2));
        end
        if (!owe[k]) begin
          n_cmp++;
          if (rdata1 !== vals[k - 3] || err1 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_load[%0d]: got %h err %b want %h err 0", k - 3, rdata1, err1, vals[k - 3]);
          end
        end
        if (stall1 !== 1'b0) sb++;
        last = c; k++;
        @(negedge clk);
        if (k < 6) begin
          we1 = owe[k]; addr1 = oaddr[k]; wdata1 = (k < 3) ? vals[k] : 32'hFFFF_FFFF;
        end else begin
          req1 = 1'b0;
        end
      end else if (stall1 !== 1'b1) begin
        sb++;
      end
    end
    req1 = 1'b0;
    n_cmp++; if (k != 6) begin n_fail++; $display("FAIL b2b_count: got %0d acks want 6", k); end
    n_cmp++; if (sb != 0) begin n_fail++; $display("FAIL b2b_stall: got %0d bad cycles want 0", sb); end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack1 === 1'b1) extra++;
    end
    n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL b2b_extra_ack: got %0d want 0", extra); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_input_stability();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
